instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 4'h0, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 8'h00, instruction word driven when no valid instruction is presented.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-005 rom_addr  output  4  fetch address to program ROM; equals current PC, combinational from PC register.
REQ-006 rom_data  input  8  instruction word from ROM at rom_addr, valid same cycle (combinational ROM).
REQ-007 stall  input  1  execute stage not ready; hold fetch state.
REQ-008 jump  input  1  redirect request from execute stage, single-cycle qualifier for jump_addr.
REQ-009 jump_addr  input  4  redirect target PC.
REQ-010 halt_req  input  1  request to stop fetching permanently until reset.
REQ-011 instr  output  8  registered instruction word presented to the instruction register.
REQ-012 instr_valid  output  1  instr is a real fetched instruction (0 = bubble).
REQ-013 instr_pc  output  4  address from which instr was fetched.
REQ-014 pc_wrap  output  1  registered one-cycle pulse when PC advances 4'hF -> 4'h0.
REQ-015 halted  output  1  high while in HALT state.

Function
REQ-016 State machine SHALL have two states: RUN, HALT; RUN -> HALT on halt_req=1 sampled in RUN; HALT exits only via reset.
REQ-017 RUN, no stall/jump/halt_req: pc <= pc+1 (mod 16); instr <= rom_data; instr_pc <= pc; instr_valid <= 1.
REQ-018 PC arithmetic SHALL be 4-bit unsigned, wrapping 4'hF -> 4'h0 with no carry retained beyond pc_wrap.
REQ-019 pc_wrap SHALL be 1 for exactly the cycle after an increment from 4'hF; 0 on jump to 4'h0, on stall, and in HALT.
REQ-020 Stall (jump=0, halt_req=0): pc, instr, instr_pc, instr_valid SHALL hold previous values; pc_wrap <= 0.
REQ-021 Jump in RUN (halt_req=0): pc <= jump_addr; instr <= NOP_INSTR; instr_valid <= 0; instr_pc holds; takes effect regardless of stall (jump overrides stall).
REQ-022 Fetch from jump_addr SHALL occur the cycle after the jump; first valid instr from target appears 2 edges after jump sampled.
REQ-023 Priority, highest first: reset, halt_req, jump, stall, normal fetch.
REQ-024 halt_req in RUN: next state HALT; pc holds; instr <= NOP_INSTR; instr_valid <= 0; any simultaneous jump or stall ignored.
REQ-025 In HALT: pc, instr_pc hold; instr = NOP_INSTR; instr_valid = 0; pc_wrap = 0; halted = 1; jump, stall, halt_req ignored.
REQ-026 halted SHALL be a registered decode of state (1 only in HALT).
REQ-027 rom_addr SHALL track pc combinationally, including during stall and HALT.

Reset
REQ-028 reset=0 at a rising edge SHALL set pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, instr_pc=RESET_PC, pc_wrap=0, state=RUN, halted=0, overriding all other inputs.
REQ-029 Reset asserted mid-stall, mid-jump or in HALT SHALL produce the identical state of REQ-028; first fetch from RESET_PC on the first edge with reset=1.
REQ-030 No output SHALL change between edges except rom_addr following pc.

Verification
REQ-031 Reset then 3 free-running cycles, ROM[i]=8'h10+i -> instr = 8'h10,8'h11,8'h12 with instr_pc 0,1,2, instr_valid=1; rom_addr=3.
REQ-032 Sequential fetch from pc=4'hE -> instr_pc E,F,0; pc_wrap=1 only in cycle instr_pc=F is presented... i.e. the cycle after pc 4'hF -> 4'h0; pc_wrap=0 otherwise.
REQ-033 pc=5, stall=1 for 3 cycles -> pc=5, instr/instr_pc/instr_valid unchanged for 3 cycles; resume fetch of ROM[5].
REQ-034 pc=7, jump=1, jump_addr=4'h2, stall=1 same cycle -> next: pc=2, instr=NOP_INSTR, instr_valid=0; next: instr=ROM[2], instr_pc=2, valid=1.
REQ-035 halt_req=1 with jump=1 at pc=9 -> halted=1, pc=9, instr_valid=0 indefinitely, jumps ignored; reset=0 -> pc=0, halted=0; fetch resumes.
REQ-036 reset=0 held 2 cycles during active fetch at pc=C -> all outputs at REQ-028 values; fetch of ROM[0] on first edge after release.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: a 4-bit PC feeds a combinational program ROM, and the fetched word is
// registered into the instruction register. The stage supports stall, jump redirect and a sticky halt.
module instruction_fetch #(
  parameter logic [3:0] RESET_PC  = 4'h0,
  parameter logic [7:0] NOP_INSTR = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       stall,
  input  logic       jump,
  input  logic [3:0] jump_addr,
  input  logic       halt_req,
  output logic [7:0] instr,
  output logic       instr_valid,
  output logic [3:0] instr_pc,
  output logic       pc_wrap,
  output logic       halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t     state_reg;
  logic [3:0] pc_reg;
  logic [7:0] instr_reg;
  logic       instr_valid_reg;
  logic [3:0] instr_pc_reg;
  logic       pc_wrap_reg;
  logic       halted_reg;

  assign rom_addr    = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign instr_pc    = instr_pc_reg;
  assign pc_wrap     = pc_wrap_reg;
  assign halted      = halted_reg;

  // Priority within RUN: halt_req, then jump, then stall, then a normal fetch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      instr_reg       <= NOP_INSTR;
      instr_valid_reg <= 1'b0;
      instr_pc_reg    <= RESET_PC;
      pc_wrap_reg     <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (halt_req) begin
            state_reg       <= HALT;
            instr_reg       <= NOP_INSTR;
            instr_valid_reg <= 1'b0;
            pc_wrap_reg     <= 1'b0;
            halted_reg      <= 1'b1;
          end else if (jump) begin
            pc_reg          <= jump_addr;
            instr_reg       <= NOP_INSTR;
            instr_valid_reg <= 1'b0;
            pc_wrap_reg     <= 1'b0;
          end else if (stall) begin
            pc_wrap_reg     <= 1'b0;
          end else begin
            pc_reg          <= pc_reg + 4'd1;
            instr_reg       <= rom_data;
            instr_pc_reg    <= pc_reg;
            instr_valid_reg <= 1'b1;
            pc_wrap_reg     <= (pc_reg == 4'hF);
          end
        end
        HALT: begin
          // Only reset leaves HALT; the PC and instr_pc stay frozen.
          instr_reg       <= NOP_INSTR;
          instr_valid_reg <= 1'b0;
          pc_wrap_reg     <= 1'b0;
          halted_reg      <= 1'b1;
        end
        default: begin
          state_reg       <= RUN;
          halted_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule
